fetch_stage: RTL and testbench

//   Instruction fetch stage of the RV32I core, directly upstream of inst_mem.
//   - Holds the program counter and drives the word address into inst_mem.
//   - Captures the returned instruction into a fetch/decode register with a valid/ready handshake to decode.
//   - Accepts branch/jump redirects from execute and traps misaligned redirect targets.

---
 rtl/fetch_stage.sv | 84 ++++++++
 tb/tb_fetch_stage.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// RV32I instruction fetch stage: owns the PC, addresses inst_mem and feeds a
// valid/ready fetch/decode register. Misaligned redirect targets halt fetch in TRAP.
module fetch_stage #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] RESET_PC   = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [31:0]           imem_rdata,
    input  logic                  redirect_valid,
    input  logic [31:0]           redirect_pc,
    output logic                  id_valid,
    input  logic                  id_ready,
    output logic [31:0]           id_instr,
    output logic [31:0]           id_pc,
    output logic                  trap_misalign,
    output logic [31:0]           fetch_count
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        TRAP = 2'd2
    } state_t;

    localparam logic [31:0] NOP = 32'h00000013;

    state_t      state;
    logic [31:0] pc;
    logic        load;
    logic        redirect_misaligned;

    // Addresses beyond the memory size simply alias through the slice.
    assign imem_addr           = pc[ADDR_WIDTH+1:2];
    assign load                = !id_valid || id_ready;
    assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= BOOT;
            pc            <= RESET_PC;
            id_valid      <= 1'b0;
            id_instr      <= NOP;
            id_pc         <= 32'h0;
            trap_misalign <= 1'b0;
            fetch_count   <= 32'h0;
        end else begin
            case (state)
                BOOT, RUN: begin
                    // A redirect always wins, even over a stalled or consumed id entry.
                    if (redirect_valid && redirect_misaligned) begin
                        id_valid      <= 1'b0;
                        trap_misalign <= 1'b1;
                        state         <= TRAP;
                    end else if (redirect_valid) begin
                        pc       <= redirect_pc;
                        id_valid <= 1'b0;
                        state    <= RUN;
                    end else if (state == RUN && load) begin
                        id_instr    <= imem_rdata;
                        id_pc       <= pc;
                        id_valid    <= 1'b1;
                        pc          <= pc + 32'd4;
                        fetch_count <= fetch_count + 32'd1;
                    end else if (state == BOOT) begin
                        state <= RUN;
                    end
                end
                TRAP: begin
                    if (redirect_valid && !redirect_misaligned) begin
                        pc            <= redirect_pc;
                        trap_misalign <= 1'b0;
                        state         <= RUN;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory holds mem[i]=i, expectations are hand-computed
// per cycle for boot, backpressure, redirect, trap, PC wrap and asynchronous reset.
module tb_fetch_stage;

    localparam int ADDR_WIDTH = 12;

    logic                  clk;
    logic                  rst;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic [31:0]           imem_rdata;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  id_valid;
    logic                  id_ready;
    logic [31:0]           id_instr;
    logic [31:0]           id_pc;
    logic                  trap_misalign;
    logic [31:0]           fetch_count;

    int compare_count;
    int mismatch_count;

    fetch_stage #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .RESET_PC  (32'h0)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .trap_misalign (trap_misalign),
        .fetch_count   (fetch_count)
    );

    // Instruction memory model: word i holds the value i.
    assign imem_rdata = 32'(imem_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compare_count++;
        if (observed !== expected) begin
            mismatch_count++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic rv, input logic [31:0] rpc, input logic ready);
        redirect_valid = rv;
        redirect_pc    = rpc;
        id_ready       = ready;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_id(input string tag, input logic valid, input logic [31:0] instr,
                            input logic [31:0] pc, input logic [31:0] count);
        checkOutput({tag, ".valid"}, 32'(id_valid), 32'(valid));
        if (valid) begin
            checkOutput({tag, ".instr"}, id_instr, instr);
            checkOutput({tag, ".pc"}, id_pc, pc);
        end
        checkOutput({tag, ".count"}, fetch_count, count);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        mismatch_count++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compare_count  = 0;
        mismatch_count = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1);

        // Reset values
        next_cycle();
        checkOutput("rst.valid", 32'(id_valid), 32'd0);
        checkOutput("rst.instr", id_instr, 32'h00000013);
        checkOutput("rst.pc", id_pc, 32'h0);
        checkOutput("rst.trap", 32'(trap_misalign), 32'd0);
        checkOutput("rst.count", fetch_count, 32'd0);
        checkOutput("rst.addr", 32'(imem_addr), 32'd0);
        next_cycle();
        rst = 1'b0;

        // Boot cycle loads nothing, then one instruction per cycle
        next_cycle();
        check_id("boot", 1'b0, 32'h0, 32'h0, 32'd0);
        next_cycle();
        check_id("run0", 1'b1, 32'd0, 32'h0, 32'd1);
        next_cycle();
        check_id("run1", 1'b1, 32'd1, 32'h4, 32'd2);
        next_cycle();
        check_id("run2", 1'b1, 32'd2, 32'h8, 32'd3);
        checkOutput("run2.addr", 32'(imem_addr), 32'd3);

        // Backpressure holds the id register and the PC
        applyStimulus(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_id("stall", 1'b1, 32'd2, 32'h8, 32'd3);
            checkOutput("stall.addr", 32'(imem_addr), 32'd3);
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        next_cycle();
        check_id("unstall", 1'b1, 32'd3, 32'hC, 32'd4);

        // Redirect during a stall discards the held instruction
        applyStimulus(1'b1, 32'h40, 1'b0);
        next_cycle();
        check_id("redir", 1'b0, 32'h0, 32'h0, 32'd4);
        checkOutput("redir.addr", 32'(imem_addr), 32'd16);
        applyStimulus(1'b0, 32'h0, 1'b1);
        next_cycle();
        check_id("redir.tgt", 1'b1, 32'd16, 32'h40, 32'd5);

        // Misaligned redirect traps; misaligned redirect in TRAP is ignored
        applyStimulus(1'b1, 32'h42, 1'b1);
        next_cycle();
        checkOutput("trap.flag", 32'(trap_misalign), 32'd1);
        check_id("trap", 1'b0, 32'h0, 32'h0, 32'd5);
        checkOutput("trap.addr", 32'(imem_addr), 32'd17);
        applyStimulus(1'b1, 32'h13, 1'b1);
        next_cycle();
        checkOutput("trap.ign.flag", 32'(trap_misalign), 32'd1);
        checkOutput("trap.ign.addr", 32'(imem_addr), 32'd17);
        applyStimulus(1'b0, 32'h0, 1'b1);
        next_cycle();
        check_id("trap.hold", 1'b0, 32'h0, 32'h0, 32'd5);
        checkOutput("trap.hold.flag", 32'(trap_misalign), 32'd1);
        applyStimulus(1'b1, 32'h10, 1'b1);
        next_cycle();
        checkOutput("trap.exit.flag", 32'(trap_misalign), 32'd0);
        check_id("trap.exit", 1'b0, 32'h0, 32'h0, 32'd5);
        applyStimulus(1'b0, 32'h0, 1'b1);
        next_cycle();
        check_id("trap.tgt", 1'b1, 32'd4, 32'h10, 32'd6);

        // PC wraps modulo 2^32 and the memory address wraps with it
        applyStimulus(1'b1, 32'hFFFFFFFC, 1'b1);
        next_cycle();
        checkOutput("wrap.addr", 32'(imem_addr), 32'hFFF);
        applyStimulus(1'b0, 32'h0, 1'b1);
        next_cycle();
        check_id("wrap.top", 1'b1, 32'hFFF, 32'hFFFFFFFC, 32'd7);
        checkOutput("wrap.addr0", 32'(imem_addr), 32'd0);
        next_cycle();
        check_id("wrap.zero", 1'b1, 32'd0, 32'h0, 32'd8);

        // Asynchronous reset between edges while trapped
        applyStimulus(1'b1, 32'h6, 1'b1);
        next_cycle();
        checkOutput("pre.flag", 32'(trap_misalign), 32'd1);
        checkOutput("pre.addr", 32'(imem_addr), 32'd1);
        applyStimulus(1'b0, 32'h0, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst.flag", 32'(trap_misalign), 32'd0);
        checkOutput("arst.valid", 32'(id_valid), 32'd0);
        checkOutput("arst.addr", 32'(imem_addr), 32'd0);
        checkOutput("arst.count", fetch_count, 32'd0);
        checkOutput("arst.instr", id_instr, 32'h00000013);
        next_cycle();
        rst = 1'b0;
        next_cycle();
        next_cycle();
        check_id("rerun", 1'b1, 32'd0, 32'h0, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, mismatch_count);
        $finish;
    end

endmodule
